// File: rtl/fetch_buffer.sv
// Instruction fetch queue: issues word-aligned fetches, tracks responses in flight and queues instructions for decode.
// Latency: a response accepted at cycle t appears at the head at t+1; the first request follows reset release or a redirect by one cycle.
// Backpressure: requests are issued only while queued plus in-flight entries < DEPTH, so a response always finds a free slot.
module fetch_buffer #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            out_valid,
  output logic [XLEN-1:0] out_pc,
  output logic [31:0]     out_inst,
  input  logic            out_ready,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [CW:0]     CREDIT_LIM = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]   DEPTH_C    = CW'(DEPTH);
  localparam logic [CW-1:0]   CNT_ONE    = CW'(1);
  localparam logic [PW-1:0]   PTR_ONE    = PW'(1);
  localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

  logic [31:0]     mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] head_pc;
  logic            run;

  logic [CW:0]     in_use;
  logic            grant;
  logic            resp;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic            unused_low_bits;

  // Queued plus in-flight entries form the credit budget; a response with nothing in flight is stale and ignored.
  assign in_use    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req  = run & ~redirect & (in_use < CREDIT_LIM);
  assign imem_addr = fetch_pc;
  assign grant     = imem_req & imem_gnt;
  assign resp      = imem_rvalid & (outstanding != '0);
  assign push      = resp & ~redirect & (drop_cnt == '0);
  assign pop       = out_valid & out_ready & ~redirect;
  assign target_pc = {redirect_pc[XLEN-1:2], 2'b00};

  assign unused_low_bits = ^redirect_pc[1:0];

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign out_valid = ~empty;
  assign out_pc    = head_pc;
  assign out_inst  = mem[rd_ptr];

  // Fetching starts on the first clock edge after reset release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) run <= 1'b0;
    else      run <= 1'b1;
  end

  // Fetch address: advances on each accepted request, reloaded by a redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= target_pc;
    else if (grant)    fetch_pc <= fetch_pc + PC_STEP;
  end

  // In-flight request count; a redirect suppresses the request so only the response side can move it then.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      outstanding <= '0;
    end else begin
      case ({grant, resp})
        2'b10:   outstanding <= outstanding + CNT_ONE;
        2'b01:   outstanding <= outstanding - CNT_ONE;
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Responses still owed to the old path after a redirect are discarded as they arrive.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                           drop_cnt <= '0;
    else if (redirect)                  drop_cnt <= outstanding - (resp ? CNT_ONE : '0);
    else if (resp && drop_cnt != '0)    drop_cnt <= drop_cnt - CNT_ONE;
  end

  // Queue occupancy, pointers and head PC; a redirect flushes everything and retargets the head.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      head_pc <= RESET_PC;
    end else if (redirect) begin
      count   <= '0;
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      head_pc <= target_pc;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr  <= rd_ptr + PTR_ONE;
        head_pc <= head_pc + PC_STEP;
      end
    end
  end

  // Instruction storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= imem_rdata;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        out_ready = 1'b0;
  logic        empty;
  logic        full;

  fetch_buffer #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst),
    .out_ready(out_ready), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Memory responder: in-order pending requests, each tagged with the flush epoch it was issued in.
  logic [31:0] pend_addr[$];
  int          pend_epoch[$];
  int          pend_due[$];
  int          cyc = 0;
  int          last_due = 0;
  int          lat_lo = 1;
  int          lat_hi = 1;
  int          epoch = 0;
  int          untracked = 0;

  // Reference model: expected decode stream as queues, plus the next address to be fetched.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_inst[$];
  logic [31:0] m_fetch = RESET_PC;
  bit          m_run = 1'b0;

  logic        s_req, s_valid, s_full;
  logic [31:0] s_addr, s_pc;

  typedef struct {
    bit          do_rst;
    bit          redir;
    logic [31:0] rpc;
    bit          gnt;
    bit          rdy;
    bit          e_req;
    logic [31:0] e_addr;
    bit          e_valid;
    logic [31:0] e_pc;
    bit          e_full;
  } vec_t;

  vec_t vec [23];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle against the model, then advance the model.
  task automatic cycle(input bit redir, input logic [31:0] rpc, input bit gnt, input bit rdy);
    bit rv, exp_req, pop, push;
    int due;
    redirect    = redir;
    redirect_pc = rpc;
    imem_gnt    = gnt;
    out_ready   = rdy;
    rv          = (pend_addr.size() > 0) && (pend_due[0] <= cyc);
    imem_rvalid = rv;
    imem_rdata  = rv ? inst_of(pend_addr[0]) : 32'hDEAD_BEEF;
    @(negedge clk);
    s_req = imem_req; s_addr = imem_addr; s_valid = out_valid; s_pc = out_pc; s_full = full;
    exp_req = m_run && !redir && ((mq_pc.size() + pend_addr.size() - untracked) < DEPTH);
    chk("imem_req", 32'(imem_req), 32'(exp_req));
    if (exp_req) chk("imem_addr", imem_addr, m_fetch);
    chk("out_valid", 32'(out_valid), 32'(mq_pc.size() != 0));
    chk("empty", 32'(empty), 32'(mq_pc.size() == 0));
    chk("full", 32'(full), 32'(mq_pc.size() == DEPTH));
    if (mq_pc.size() != 0) begin
      chk("out_pc", out_pc, mq_pc[0]);
      chk("out_inst", out_inst, mq_inst[0]);
    end
    pop  = (mq_pc.size() != 0) && rdy && !redir;
    push = rv && !redir && (pend_epoch[0] == epoch);
    if (redir) begin
      mq_pc.delete();
      mq_inst.delete();
      epoch++;
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_inst.pop_front());
      end
      if (push) begin
        mq_pc.push_back(pend_addr[0]);
        mq_inst.push_back(inst_of(pend_addr[0]));
      end
    end
    if (rv) begin
      if (pend_epoch[0] < 0) untracked--;
      void'(pend_addr.pop_front());
      void'(pend_epoch.pop_front());
      void'(pend_due.pop_front());
    end
    if (exp_req && gnt) begin
      due = cyc + int'($urandom_range(lat_hi, lat_lo));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      pend_addr.push_back(m_fetch);
      pend_epoch.push_back(epoch);
      pend_due.push_back(due);
      m_fetch = m_fetch + 32'd4;
    end
    if (redir) m_fetch = {rpc[31:2], 2'b00};
    m_run = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Assert reset for two edges; keep_stale leaves earlier requests to be answered after release.
  task automatic do_reset(input bit keep_stale);
    rst = 1'b0;
    redirect = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; out_ready = 1'b0;
    #1;
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_imem_addr", imem_addr, RESET_PC);
    chk("rst_out_pc", out_pc, RESET_PC);
    if (keep_stale) begin
      foreach (pend_epoch[i]) pend_epoch[i] = -1;
      untracked = pend_addr.size();
    end else begin
      pend_addr.delete(); pend_epoch.delete(); pend_due.delete();
      untracked = 0;
      last_due = 0;
    end
    mq_pc.delete();
    mq_inst.delete();
    m_fetch = RESET_PC;
    m_run = 1'b0;
    epoch++;
    repeat (2) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    rst = 1'b1;
  endtask

  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      cycle(1'b0, 32'h0, 1'b1, 1'b1);
      if (s_valid) found = 1'b1;
    end
    if (found) begin
      chk({name, "_first_pc"}, s_pc, exp_pc);
    end else begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no out_valid required=out_valid within 30 cycles", name);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=still running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // do_rst redir rpc gnt rdy | e_req e_addr e_valid e_pc e_full
    // Reset release, full-rate stream.
    vec[0]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0};
    vec[1]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0};
    vec[2]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0};
    vec[3]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h0, 1'b0};
    vec[4]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h4, 1'b0};
    vec[5]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h8, 1'b0};
    // Decode stalled: fill to DEPTH, one pop frees exactly one request.
    vec[6]  = '{1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 32'h0, 1'b0};
    vec[7]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0};
    vec[8]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0};
    vec[9]  = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h08, 1'b1, 32'h0, 1'b0};
    vec[10] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h0C, 1'b1, 32'h0, 1'b0};
    vec[11] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 1'b0};
    vec[12] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h10, 1'b1, 32'h0, 1'b1};
    vec[13] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h10, 1'b1, 32'h0, 1'b1};
    vec[14] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h10, 1'b1, 32'h4, 1'b0};
    vec[15] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4, 1'b0};
    vec[16] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4, 1'b1};
    // Misaligned redirect target, then fetch address wrap at the top of the space.
    vec[17] = '{1'b0, 1'b1, 32'h7, 1'b1, 1'b0, 1'b0, 32'h14, 1'b1, 32'h4, 1'b1};
    vec[18] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b0, 32'h0, 1'b0};
    vec[19] = '{1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, 32'h08, 1'b0, 32'h0, 1'b0};
    vec[20] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b0};
    vec[21] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h00, 1'b0, 32'h0, 1'b0};
    vec[22] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 32'h04, 1'b1, 32'hFFFF_FFFC, 1'b0};

    lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 23; i++) begin
      if (vec[i].do_rst) do_reset(1'b0);
      cycle(vec[i].redir, vec[i].rpc, vec[i].gnt, vec[i].rdy);
      chk($sformatf("vec%0d_req", i), 32'(s_req), 32'(vec[i].e_req));
      chk($sformatf("vec%0d_addr", i), s_addr, vec[i].e_addr);
      chk($sformatf("vec%0d_valid", i), 32'(s_valid), 32'(vec[i].e_valid));
      if (vec[i].e_valid) chk($sformatf("vec%0d_pc", i), s_pc, vec[i].e_pc);
      chk($sformatf("vec%0d_full", i), 32'(s_full), 32'(vec[i].e_full));
    end

    // Three requests in flight, redirect: old responses discarded, stream restarts at the target.
    do_reset(1'b0);
    lat_lo = 4; lat_hi = 4;
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h104, 1'b1, 1'b1);
    chk("redir_req_low", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("redir_next_req", 32'(s_req), 32'd1);
    chk("redir_next_addr", s_addr, 32'h104);
    wait_valid("redir", 32'h104);

    // Redirect coinciding with a response and a pop.
    do_reset(1'b0);
    lat_lo = 2; lat_hi = 2;
    repeat (4) cycle(1'b0, 32'h0, 1'b1, 1'b1);
    cycle(1'b1, 32'h200, 1'b1, 1'b1);
    chk("collide_valid_before", 32'(s_valid), 32'd1);
    cycle(1'b0, 32'h0, 1'b1, 1'b1);
    chk("collide_valid_after", 32'(s_valid), 32'd0);
    chk("collide_addr", s_addr, 32'h200);
    wait_valid("collide", 32'h200);

    // Reset with two requests in flight; their late responses must not enter the queue.
    do_reset(1'b0);
    lat_lo = 3; lat_hi = 3;
    repeat (3) cycle(1'b0, 32'h0, 1'b1, 1'b0);
    do_reset(1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stale1_valid", 32'(s_valid), 32'd0);
    chk("stale1_req", 32'(s_req), 32'd0);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("stale2_valid", 32'(s_valid), 32'd0);
    chk("stale2_req", 32'(s_req), 32'd1);
    chk("stale2_addr", s_addr, RESET_PC);
    wait_valid("stale", RESET_PC);

    // Randomized traffic against the model.
    do_reset(1'b0);
    lat_lo = 1; lat_hi = 4;
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(99, 0) < 4, $urandom, $urandom_range(9, 0) < 7, $urandom_range(9, 0) < 6);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
